// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
//   opcode, equal, mem_ready : datapath/memory -> controller
//   pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
//   alu_src_imm              : controller strobes -> datapath
//   state, instr_done, fault : controller status
// master = controller side, slave = datapath/memory side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       equal;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_imm;
    logic [3:0] state;
    logic       instr_done;
    logic       fault;

    modport master (
        input  opcode, equal, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               alu_src_imm, state, instr_done, fault
    );

    modport slave (
        output opcode, equal, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               alu_src_imm, state, instr_done, fault
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller (lw, sw, R-type, addi, beq, j).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; forces FETCH immediately
//   bus   : multicycle_control_if.master (opcode/equal/mem_ready in,
//           datapath strobes, state code, instr_done and fault out)
// Parameter STALL_LIMIT: consecutive mem_ready=0 cycles tolerated in one
// memory state (FETCH, MEM_RD, MEM_WR) before the FSM traps in ERROR.
module multicycle_control #(
    parameter int STALL_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ERROR    = 4'd15
    } state_t;

    state_t          state_reg, state_next;
    logic [5:0]      opcode_reg, opcode_next;
    logic [CW-1:0]   stall_reg, stall_next;
    logic            stalled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            opcode_reg <= '0;
            stall_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            stall_reg  <= stall_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        opcode_next     = opcode_reg;
        stall_next      = '0;
        stalled         = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'b00;
        bus.ir_write    = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.instr_done  = 1'b0;

        case (state_reg)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_next   = S_DECODE;
                end else begin
                    stalled = 1'b1;
                end
            end
            S_DECODE: begin
                opcode_next = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW:       state_next = S_MEM_ADDR;
                    OP_RTYPE, OP_ADDI:  state_next = S_EXEC;
                    OP_BEQ:             state_next = S_BRANCH;
                    OP_J:               state_next = S_JUMP;
                    default:            state_next = S_ERROR;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_imm = 1'b1;
                // Only lw/sw reach here, so the latched opcode picks the path.
                state_next = (opcode_reg == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_next = S_MEM_WB;
                else               stalled    = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end else begin
                    stalled = 1'b1;
                end
            end
            S_MEM_WB, S_ALU_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_EXEC: begin
                bus.alu_src_imm = (opcode_reg == OP_ADDI);
                state_next      = S_ALU_WB;
            end
            S_BRANCH: begin
                bus.pc_src     = 2'b01;
                bus.pc_write   = bus.equal;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src     = 2'b10;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            default: begin
                // ERROR and unused codes trap until reset.
                state_next = S_ERROR;
            end
        endcase

        // The counter only survives while the FSM sits stalled in place;
        // the STALL_LIMIT-th stalled cycle is the last one before ERROR.
        if (stalled) begin
            if (stall_reg == STALL_LAST) state_next = S_ERROR;
            else                         stall_next = stall_reg + CW'(1);
        end

        // During reset the outputs must already look like an idle FETCH,
        // even before any clock edge and regardless of mem_ready.
        if (reset) begin
            bus.pc_write    = 1'b0;
            bus.pc_src      = 2'b00;
            bus.ir_write    = 1'b0;
            bus.mem_read    = 1'b1;
            bus.mem_write   = 1'b0;
            bus.reg_write   = 1'b0;
            bus.alu_src_imm = 1'b0;
            bus.instr_done  = 1'b0;
        end
    end

    assign bus.state = state_reg;
    assign bus.fault = (state_reg == S_ERROR) && !reset;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int LIMIT = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if mc_if ();

    multicycle_control #(.STALL_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mc_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each instruction is a path of state codes; memory
    // codes (0,3,5) wait for mem_ready, everything else advances every cycle.
    int         m_path[$];
    int         m_idx;
    int         m_stall;
    bit         m_fault;
    logic [5:0] m_lop;
    int         m_done_cnt;

    logic [5:0] legal_ops [6];

    function automatic void m_reset();
        m_path  = '{0, 1};
        m_idx   = 0;
        m_stall = 0;
        m_fault = 1'b0;
        m_lop   = 6'd0;
    endfunction

    function automatic int m_state();
        return m_fault ? 15 : m_path[m_idx];
    endfunction

    function automatic void m_step(input logic [5:0] op, input logic mr);
        int c;
        c = m_state();
        if (m_fault) return;
        if (c == 0 || c == 3 || c == 5) begin
            if (!mr) begin
                m_stall++;
                if (m_stall == LIMIT) m_fault = 1'b1;
                return;
            end
            m_stall = 0;
            m_idx++;
        end else if (c == 1) begin
            m_lop = op;
            case (op)
                6'b100011: m_path = '{0, 1, 2, 3, 4};
                6'b101011: m_path = '{0, 1, 2, 5};
                6'b000000,
                6'b001000: m_path = '{0, 1, 6, 7};
                6'b000100: m_path = '{0, 1, 8};
                6'b000010: m_path = '{0, 1, 9};
                default: begin
                    m_fault = 1'b1;
                    return;
                end
            endcase
            m_idx++;
        end else begin
            m_idx++;
        end
        if (m_idx >= m_path.size()) begin
            m_path = '{0, 1};
            m_idx  = 0;
            m_done_cnt++;
        end
    endfunction

    // Packed view: {state, fault, done, pc_write, pc_src, ir_write,
    //               mem_read, mem_write, reg_write, alu_src_imm}
    function automatic logic [13:0] m_outputs(input logic mr, input logic eq);
        logic [3:0] st;
        logic f, d, pw, ir, rd, wr, rw, alu;
        logic [1:0] ps;
        int c;
        c = m_state();
        st = 4'(c);
        {f, d, pw, ir, rd, wr, rw, alu} = '0;
        ps = 2'b00;
        case (c)
            0:  begin rd = 1; ir = mr; pw = mr; end
            2:  alu = 1;
            3:  rd = 1;
            4, 7: begin rw = 1; d = 1; end
            5:  begin wr = 1; d = mr; end
            6:  alu = (m_lop == 6'b001000);
            8:  begin ps = 2'b01; pw = eq; d = 1; end
            9:  begin ps = 2'b10; pw = 1; d = 1; end
            15: f = 1;
            default: ;
        endcase
        return {st, f, d, pw, ps, ir, rd, wr, rw, alu};
    endfunction

    function automatic logic [13:0] dut_outputs();
        return {mc_if.state, mc_if.fault, mc_if.instr_done, mc_if.pc_write,
                mc_if.pc_src, mc_if.ir_write, mc_if.mem_read, mc_if.mem_write,
                mc_if.reg_write, mc_if.alu_src_imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with inputs already driven; checks mid-cycle,
    // then advances the model on the edge.
    task automatic run_cycle(input string tag);
        logic [13:0] exp;
        #2;
        exp = m_outputs(mc_if.mem_ready, mc_if.equal);
        $display("cyc %s op=%b mr=%b eq=%b state=%0d exp=%0d",
                 tag, mc_if.opcode, mc_if.mem_ready, mc_if.equal,
                 mc_if.state, exp[13:10]);
        check({tag, "_outputs"}, 32'(dut_outputs()), 32'(exp));
        check({tag, "_rd_wr_excl"}, 32'(mc_if.mem_read & mc_if.mem_write), 32'd0);
        @(posedge clk);
        m_step(mc_if.opcode, mc_if.mem_ready);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [5:0] op,
                       input logic mr, input logic eq);
        mc_if.opcode    = op;
        mc_if.mem_ready = mr;
        mc_if.equal     = eq;
        run_cycle(tag);
    endtask

    // Asynchronous reset pulse issued mid-cycle; outputs must switch at once.
    task automatic do_reset(input string tag);
        mc_if.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        $display("rst %s state=%0d fault=%b", tag, mc_if.state, mc_if.fault);
        check({tag, "_async"}, 32'(dut_outputs()),
              32'({4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        int start_done;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                      6'b000100, 6'b000010};
        m_done_cnt      = 0;
        mc_if.opcode    = 6'd0;
        mc_if.mem_ready = 1'b1;
        mc_if.equal     = 1'b0;
        m_reset();

        // Reset held from time zero.
        #3;
        check("reset_init", 32'(dut_outputs()),
              32'({4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lw, zero wait: 0,1,2,3,4 with a single done pulse.
        start_done = m_done_cnt;
        cyc("lw_f",  6'b100011, 1, 0);
        cyc("lw_d",  6'b100011, 1, 0);
        cyc("lw_a",  6'b111111, 1, 0);   // opcode change after DECODE ignored
        cyc("lw_r",  6'b101011, 1, 0);
        cyc("lw_wb", 6'b000100, 1, 0);
        check("lw_done_count", 32'(m_done_cnt - start_done), 32'd1);

        // beq taken / not taken.
        cyc("beq1_f", 6'b000100, 1, 1);
        cyc("beq1_d", 6'b000100, 1, 1);
        cyc("beq1_b", 6'b000100, 1, 1);
        cyc("beq0_f", 6'b000100, 1, 0);
        cyc("beq0_d", 6'b000100, 1, 0);
        cyc("beq0_b", 6'b000100, 1, 0);

        // FETCH stalls three cycles, then j.
        cyc("fst_0", 6'b000010, 0, 0);
        cyc("fst_1", 6'b000010, 0, 0);
        cyc("fst_2", 6'b000010, 0, 0);
        cyc("fst_3", 6'b000010, 1, 0);
        cyc("j_d",   6'b000010, 1, 0);
        cyc("j_j",   6'b000010, 1, 0);

        // addi and R-type through EXEC.
        cyc("addi_f", 6'b001000, 1, 0);
        cyc("addi_d", 6'b001000, 1, 0);
        cyc("addi_e", 6'b000000, 1, 0);
        cyc("addi_w", 6'b000000, 1, 0);
        cyc("r_f",    6'b000000, 1, 0);
        cyc("r_d",    6'b000000, 1, 0);
        cyc("r_e",    6'b001000, 1, 0);
        cyc("r_w",    6'b001000, 1, 0);

        // sw stalled in MEM_WR until the limit trips.
        cyc("sw_f", 6'b101011, 1, 0);
        cyc("sw_d", 6'b101011, 1, 0);
        cyc("sw_a", 6'b100011, 1, 0);
        for (int i = 0; i < LIMIT; i++) cyc("sw_stall", 6'b101011, 0, 0);
        cyc("sw_err0", 6'b101011, 0, 0);
        cyc("sw_err1", 6'b101011, 1, 0);
        check("sw_fault", 32'(mc_if.fault), 32'd1);
        do_reset("after_stall");

        // Illegal opcode traps straight from DECODE.
        cyc("ill_f", 6'b111111, 1, 0);
        cyc("ill_d", 6'b111111, 1, 0);
        cyc("ill_e", 6'b100011, 1, 0);
        do_reset("after_illegal");

        // Reset during MEM_RD abandons the lw.
        cyc("ab_f", 6'b100011, 1, 0);
        cyc("ab_d", 6'b100011, 1, 0);
        cyc("ab_a", 6'b100011, 1, 0);
        cyc("ab_r", 6'b100011, 0, 0);
        do_reset("mid_mem_rd");
        cyc("ab_f2", 6'b000010, 1, 0);
        cyc("ab_d2", 6'b000010, 1, 0);
        cyc("ab_j2", 6'b000010, 1, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 19) == 0) op = 6'($urandom);
            else                            op = legal_ops[$urandom_range(0, 5)];
            cyc("rnd", op, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            if (m_fault && $urandom_range(0, 2) == 0) do_reset("rnd_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
